// File: rtl/cell_pixel_scaler_if.sv
// Cell request and VGA pixel signals between draw controller, scaler and adapter.
// The slave modport is the scaler's view; master is the controller/adapter side.
interface cell_pixel_scaler_if #(
  parameter int CELL_W = 2,
  parameter int X_W    = 8,
  parameter int Y_W    = 7
) ();
  logic              in_plot;
  logic [CELL_W-1:0] in_x;
  logic [CELL_W-1:0] in_y;
  logic [2:0]        in_colour;
  logic              in_ready;
  logic              vga_plot;
  logic [X_W-1:0]    vga_x;
  logic [Y_W-1:0]    vga_y;
  logic [2:0]        vga_colour;

  modport master (
    output in_plot, in_x, in_y, in_colour,
    input  in_ready,
    input  vga_plot, vga_x, vga_y, vga_colour
  );

  modport slave (
    input  in_plot, in_x, in_y, in_colour,
    output in_ready,
    output vga_plot, vga_x, vga_y, vga_colour
  );
endinterface

// File: rtl/cell_pixel_scaler.sv
// Paints queued board cells as CELL_SIZE x CELL_SIZE pixel squares for VGA.
// Define CELL_BORDER_EN to blacken each cell's top row and left column.
module cell_pixel_scaler #(
  parameter int CELL_W     = 2,
  parameter int CELL_SHIFT = 3,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int X_ORIGIN   = 0,
  parameter int Y_ORIGIN   = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clock,
  input  logic resetn,
  cell_pixel_scaler_if.slave bus,
  output logic busy,
  output logic overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = 2 * CELL_W + 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PAINT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DW-1:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wp;
  logic [AW-1:0]         r_rp;
  logic [CW-1:0]         r_cnt;
  logic                  r_ovf;
  logic [CELL_W-1:0]     r_cx;
  logic [CELL_W-1:0]     r_cy;
  logic [2:0]            r_cc;
  logic [2:0]            r_col;
  logic [X_W-1:0]        r_bx;
  logic [Y_W-1:0]        r_by;
  logic [CELL_SHIFT-1:0] r_px;
  logic [CELL_SHIFT-1:0] r_py;
  logic [X_W-1:0]        r_hx;
  logic [Y_W-1:0]        r_hy;
  logic [2:0]            r_hc;

  logic                  w_ready;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_paint;
  logic                  w_last;
  logic [DW-1:0]         w_head;
  logic [X_W-1:0]        w_vx;
  logic [Y_W-1:0]        w_vy;
  logic [2:0]            w_vc;
  logic [CELL_SHIFT-1:0] w_pmax;

  assign w_pmax  = '1;
  assign w_ready = (r_cnt != CW'(FIFO_DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_push  = bus.in_plot & w_ready;
  assign w_head  = r_mem[r_rp];
  assign w_paint = (r_state == S_PAINT);
  assign w_last  = (r_px == w_pmax) && (r_py == w_pmax);

  assign w_vx = r_bx + X_W'(r_px);
  assign w_vy = r_by + Y_W'(r_py);

`ifdef CELL_BORDER_EN
  assign w_vc = (r_px == '0 || r_py == '0) ? 3'b000 : r_col;
`else
  assign w_vc = r_col;
`endif

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wp] <= {bus.in_x, bus.in_y, bus.in_colour};
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (bus.in_plot && !w_ready) r_ovf <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_LOAD;
        end
      end
      S_LOAD: w_next = S_PAINT;
      S_PAINT: begin
        if (w_last) begin
          w_pop  = !w_empty;
          w_next = w_empty ? S_IDLE : S_LOAD;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cx    <= '0;
      r_cy    <= '0;
      r_cc    <= '0;
      r_col   <= '0;
      r_bx    <= '0;
      r_by    <= '0;
      r_px    <= '0;
      r_py    <= '0;
      r_hx    <= '0;
      r_hy    <= '0;
      r_hc    <= '0;
    end else begin
      r_state <= w_next;
      if (w_pop) begin
        r_cx <= w_head[DW-1 -: CELL_W];
        r_cy <= w_head[3 +: CELL_W];
        r_cc <= w_head[2:0];
      end
      if (r_state == S_LOAD) begin
        r_bx  <= X_W'(X_ORIGIN) + (X_W'(r_cx) << CELL_SHIFT);
        r_by  <= Y_W'(Y_ORIGIN) + (Y_W'(r_cy) << CELL_SHIFT);
        r_col <= r_cc;
        r_px  <= '0;
        r_py  <= '0;
      end
      if (w_paint) begin
        // hold the last painted pixel so vga_* stay stable between cells
        r_hx <= w_vx;
        r_hy <= w_vy;
        r_hc <= w_vc;
        r_px <= r_px + CELL_SHIFT'(1);
        if (r_px == w_pmax) r_py <= r_py + CELL_SHIFT'(1);
      end
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.vga_plot   = w_paint;
  assign bus.vga_x      = w_paint ? w_vx : r_hx;
  assign bus.vga_y      = w_paint ? w_vy : r_hy;
  assign bus.vga_colour = w_paint ? w_vc : r_hc;
  assign busy           = !w_empty || (r_state != S_IDLE);
  assign overflow       = r_ovf;

endmodule

// File: tb/tb_cell_pixel_scaler.sv
// Directed bench for cell_pixel_scaler with a pixel scoreboard.
// Instance b uses X_ORIGIN=250 to exercise coordinate wrap.
module tb_cell_pixel_scaler;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic busy_a, ovf_a, busy_b, ovf_b;

  int n_cmp = 0;
  int n_bad = 0;
  int npix_a = 0;
  int nzero_a = 0;
  int npix_b = 0;

  logic [17:0] qa[$];
  logic [17:0] qb[$];

  always #5 clock = ~clock;

  cell_pixel_scaler_if #(.CELL_W(2), .X_W(8), .Y_W(7)) ifa ();
  cell_pixel_scaler_if #(.CELL_W(2), .X_W(8), .Y_W(7)) ifb ();

  cell_pixel_scaler dut_a (
    .clock    (clock),
    .resetn   (resetn),
    .bus      (ifa),
    .busy     (busy_a),
    .overflow (ovf_a)
  );

  cell_pixel_scaler #(.X_ORIGIN(250)) dut_b (
    .clock    (clock),
    .resetn   (resetn),
    .bus      (ifb),
    .busy     (busy_b),
    .overflow (ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cell(input bit sel_b, input int x, input int y,
                             input logic [2:0] c);
    int xo;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    xo = sel_b ? 250 : 0;
    for (int py = 0; py < 8; py++) begin
      for (int px = 0; px < 8; px++) begin
        ex = 8'(xo + x * 8 + px);
        ey = 7'(y * 8 + py);
        ec = c;
`ifdef CELL_BORDER_EN
        if (px == 0 || py == 0) ec = 3'b000;
`endif
        if (sel_b) qb.push_back({ex, ey, ec});
        else qa.push_back({ex, ey, ec});
      end
    end
  endtask

  task automatic tick();
    logic [17:0] e;
    @(posedge clock);
    #1;
    if (ifa.vga_plot) begin
      npix_a++;
      if (ifa.vga_colour == 3'b000) nzero_a++;
      if (qa.size() == 0) check("a_unexpected_pixel", 1, 0);
      else begin
        e = qa.pop_front();
        check("a_pixel", {ifa.vga_x, ifa.vga_y, ifa.vga_colour}, e);
      end
    end
    if (ifb.vga_plot) begin
      npix_b++;
      if (qb.size() == 0) check("b_unexpected_pixel", 1, 0);
      else begin
        e = qb.pop_front();
        check("b_pixel", {ifb.vga_x, ifb.vga_y, ifb.vga_colour}, e);
      end
    end
  endtask

  task automatic drain_a(input int budget);
    int n;
    n = 0;
    while (qa.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("a_drain_left", qa.size(), 0);
  endtask

  initial begin
    ifa.in_plot = 0; ifa.in_x = 0; ifa.in_y = 0; ifa.in_colour = 0;
    ifb.in_plot = 0; ifb.in_x = 0; ifb.in_y = 0; ifb.in_colour = 0;

    // reset
    tick();
    tick();
    check("rst_ready", ifa.in_ready, 1);
    check("rst_busy", busy_a, 0);
    check("rst_plot", ifa.vga_plot, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_xyc", {ifa.vga_x, ifa.vga_y, ifa.vga_colour}, 0);
    resetn = 1;
    tick();

    // single cell (1,2) colour 100
    npix_a = 0;
    ifa.in_plot = 1; ifa.in_x = 1; ifa.in_y = 2; ifa.in_colour = 3'b100;
    expect_cell(0, 1, 2, 3'b100);
    tick();
    ifa.in_plot = 0;
    check("busy_after_push", busy_a, 1);
    tick();
    check("lat_plot_e1", ifa.vga_plot, 0);
    tick();
    check("lat_plot_e2", ifa.vga_plot, 1);
    drain_a(200);
    check("single_npix", npix_a, 64);
    tick();
    check("single_busy_fall", busy_a, 0);
    check("single_plot_off", ifa.vga_plot, 0);
    check("single_hold_x", ifa.vga_x, 15);
    check("single_hold_y", ifa.vga_y, 23);

    // burst of 6 from idle, 5 accepted
    npix_a = 0;
    for (int i = 0; i < 6; i++) begin
      ifa.in_plot = 1;
      ifa.in_x = 2'(i % 4);
      ifa.in_y = 2'(i / 4);
      ifa.in_colour = 3'(i + 1);
      check("burst_ready", ifa.in_ready, (i < 5) ? 1 : 0);
      if (i < 5) expect_cell(0, i % 4, i / 4, 3'(i + 1));
      tick();
    end
    ifa.in_plot = 0;
    check("burst_ovf", ovf_a, 1);
    drain_a(400);
    check("burst_npix", npix_a, 320);
    tick();
    check("burst_busy_fall", busy_a, 0);

    // wrap on instance b
    npix_b = 0;
    ifb.in_plot = 1; ifb.in_x = 1; ifb.in_y = 0; ifb.in_colour = 3'b011;
    expect_cell(1, 1, 0, 3'b011);
    tick();
    ifb.in_plot = 0;
    for (int n = 0; n < 100 && qb.size() != 0; n++) tick();
    check("wrap_drain_left", qb.size(), 0);
    check("wrap_npix", npix_b, 64);
    check("wrap_ovf", ovf_b, 0);

    // reset mid-paint drops in-flight and queued cells
    npix_a = 0;
    ifa.in_plot = 1; ifa.in_x = 2; ifa.in_y = 1; ifa.in_colour = 3'b101;
    expect_cell(0, 2, 1, 3'b101);
    tick();
    ifa.in_x = 3; ifa.in_y = 3; ifa.in_colour = 3'b110;
    expect_cell(0, 3, 3, 3'b110);
    tick();
    ifa.in_plot = 0;
    for (int n = 0; n < 50 && npix_a < 10; n++) tick();
    check("mid_npix", npix_a, 10);
    resetn = 0;
    qa.delete();
    tick();
    check("mid_plot", ifa.vga_plot, 0);
    check("mid_busy", busy_a, 0);
    check("mid_ready", ifa.in_ready, 1);
    check("mid_ovf", ovf_a, 0);
    resetn = 1;
    for (int n = 0; n < 12; n++) tick();
    check("mid_quiet_busy", busy_a, 0);
    check("mid_quiet_npix", npix_a, 10);

`ifdef CELL_BORDER_EN
    npix_a = 0;
    nzero_a = 0;
    ifa.in_plot = 1; ifa.in_x = 0; ifa.in_y = 0; ifa.in_colour = 3'b010;
    expect_cell(0, 0, 0, 3'b010);
    tick();
    ifa.in_plot = 0;
    drain_a(200);
    check("border_zero", nzero_a, 15);
    check("border_col", npix_a - nzero_a, 49);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
